// File: rtl/sumador_restador_serial.sv
// rtl/sumador_restador_serial.sv - digit-serial add/subtract unit with start/busy/done handshake
// Operands enter LSB-first, DIGIT bits per clock; sign, magnitude and overflow are resolved on the last digit.
module sumador_restador_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             select,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             neg,
    output logic [WIDTH:0]   mag,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             carry;
    logic             sel_q;
    logic             sgn_q;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] r_next;
    logic             last;
    logic             cout_f;
    logic             c_msb;
    logic             ext_a;
    logic             ext_b;
    logic             r_top;
    logic [WIDTH:0]   r_full;
    logic             neg_f;
    logic [WIDTH:0]   mag_f;
    logic             ovf_f;

    assign dsum   = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign r_next = (r_sr >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last   = (cnt == CW'(N - 1));
    assign cout_f = dsum[DIGIT];

    // On the last digit the operand MSBs sit at bit DIGIT-1, so the carry into
    // the MSB falls out of the sum bit without a separate carry chain.
    assign c_msb  = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];

    // Bit WIDTH of the exact result: extension bits of A and (possibly inverted) B plus the final carry.
    assign ext_a  = sgn_q & a_sr[DIGIT-1];
    assign ext_b  = sgn_q ? b_sr[DIGIT-1] : sel_q;
    assign r_top  = ext_a ^ ext_b ^ cout_f;
    assign r_full = {r_top, r_next};

    // Unsigned addition is never negative even though its top bit can be set.
    assign neg_f  = (sgn_q | sel_q) & r_top;
    assign mag_f  = neg_f ? (~r_full + (WIDTH+1)'(1)) : r_full;
    assign ovf_f  = sgn_q ? (c_msb ^ cout_f) : (sel_q ? ~cout_f : cout_f);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            carry <= 1'b0;
            sel_q <= 1'b0;
            sgn_q <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            neg   <= 1'b0;
            mag   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B ^ {WIDTH{select}};
                        carry <= select;
                        sel_q <= select;
                        sgn_q <= signed_mode;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    r_sr  <= r_next;
                    carry <= cout_f;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        S     <= r_next;
                        Cout  <= cout_f;
                        neg   <= neg_f;
                        mag   <= mag_f;
                        ovf   <= ovf_f;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_restador_serial.sv
// tb/tb_sumador_restador_serial.sv - scoreboard bench for sumador_restador_serial (DIGIT=1 and DIGIT=4)
module tb_sumador_restador_serial;

    localparam int W  = 8;
    localparam int N1 = 8;
    localparam int N4 = 2;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         neg;
        logic [W:0]   mag;
        logic         ovf;
        int           k;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         start1 = 1'b0, sel1 = 1'b0, sgn1 = 1'b0;
    logic [W-1:0] a1 = '0, b1 = '0;
    logic         busy1, done1, cout1, neg1, ovf1;
    logic [W-1:0] s1;
    logic [W:0]   mag1;

    logic         start4 = 1'b0, sel4 = 1'b0, sgn4 = 1'b0;
    logic [W-1:0] a4 = '0, b4 = '0;
    logic         busy4, done4, cout4, neg4, ovf4;
    logic [W-1:0] s4;
    logic [W:0]   mag4;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_run1 = 0;
    int   busy_run4 = 0;
    exp_t q1[$];
    exp_t q4[$];

    sumador_restador_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
        .select(sel1), .signed_mode(sgn1), .busy(busy1), .done(done1),
        .S(s1), .Cout(cout1), .neg(neg1), .mag(mag1), .ovf(ovf1)
    );

    sumador_restador_serial #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .select(sel4), .signed_mode(sgn4), .busy(busy4), .done(done4),
        .S(s4), .Cout(cout4), .neg(neg4), .mag(mag4), .ovf(ovf4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic on the extended operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sel, input logic sgn);
        exp_t e;
        int   ai, bi, r;
        ai = sgn ? int'($signed(a)) : int'(a);
        bi = sgn ? int'($signed(b)) : int'(b);
        r  = sel ? ai - bi : ai + bi;
        e.s    = W'(r);
        e.neg  = (r < 0);
        e.mag  = (W+1)'((r < 0) ? -r : r);
        e.cout = sel ? (a >= b) : ((int'(a) + int'(b)) >= (1 << W));
        if (sgn) e.ovf = (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
        else     e.ovf = (r < 0) || (r > (1 << W) - 1);
        e.k = 0;
        return e;
    endfunction

    task automatic cmp_res(input string tag, input exp_t e, input logic [W-1:0] s, input logic c,
                           input logic ng, input logic [W:0] m, input logic o, input int lat_exp);
        check({tag, "_S"},       32'(s),  32'(e.s));
        check({tag, "_Cout"},    32'(c),  32'(e.cout));
        check({tag, "_neg"},     32'(ng), 32'(e.neg));
        check({tag, "_mag"},     32'(m),  32'(e.mag));
        check({tag, "_ovf"},     32'(o),  32'(e.ovf));
        check({tag, "_latency"}, 32'(cyc - e.k), 32'(lat_exp));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run1 = 0;
        end else if (busy1) begin
            busy_run1++;
        end else begin
            if (done1) begin
                if (q1.size() == 0) begin
                    check("d1_unexpected_done", 32'(done1), 32'd0);
                end else begin
                    cmp_res("d1", q1.pop_front(), s1, cout1, neg1, mag1, ovf1, N1);
                    check("d1_busy_cycles", 32'(busy_run1), 32'(N1));
                end
            end
            busy_run1 = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run4 = 0;
        end else if (busy4) begin
            busy_run4++;
        end else begin
            if (done4) begin
                if (q4.size() == 0) begin
                    check("d4_unexpected_done", 32'(done4), 32'd0);
                end else begin
                    cmp_res("d4", q4.pop_front(), s4, cout4, neg4, mag4, ovf4, N4);
                    check("d4_busy_cycles", 32'(busy_run4), 32'(N4));
                end
            end
            busy_run4 = 0;
        end
    end

    task automatic issue(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sel, input logic sgn, input bit push);
        exp_t e;
        e   = model(a, b, sel, sgn);
        e.k = cyc + 1;
        if (d == 1) begin
            a1 = a; b1 = b; sel1 = sel; sgn1 = sgn; start1 = 1'b1;
            if (push) q1.push_back(e);
        end else begin
            a4 = a; b4 = b; sel4 = sel; sgn4 = sgn; start4 = 1'b1;
            if (push) q4.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && (q1.size() != 0 || q4.size() != 0); i++) @(posedge clk);
        #1;
        if (q1.size() != 0 || q4.size() != 0) begin
            check("drain_timeout", 32'(q1.size() + q4.size()), 32'd0);
            q1.delete();
            q4.delete();
        end
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 20 && !((d == 1) ? done1 : done4); i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'h7F;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy1"}, 32'(busy1), 32'd0);
        check({tag, "_done1"}, 32'(done1), 32'd0);
        check({tag, "_S1"},    32'(s1),    32'd0);
        check({tag, "_Cout1"}, 32'(cout1), 32'd0);
        check({tag, "_neg1"},  32'(neg1),  32'd0);
        check({tag, "_mag1"},  32'(mag1),  32'd0);
        check({tag, "_ovf1"},  32'(ovf1),  32'd0);
        check({tag, "_S4"},    32'(s4),    32'd0);
        check({tag, "_mag4"},  32'(mag4),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Directed vectors, DIGIT=1
        issue(1, 8'd3,   8'd5,   1'b1, 1'b0, 1'b1); tick(); drain();
        issue(1, 8'd200, 8'd100, 1'b0, 1'b0, 1'b1); tick(); drain();
        issue(1, 8'd20,  8'd30,  1'b0, 1'b0, 1'b1); tick(); drain();
        issue(1, 8'h64,  8'h64,  1'b0, 1'b1, 1'b1); tick(); drain();
        issue(1, 8'h80,  8'h01,  1'b1, 1'b1, 1'b1); tick(); drain();
        issue(1, 8'h05,  8'h07,  1'b1, 1'b1, 1'b1); tick(); drain();

        // Directed vector, DIGIT=4
        issue(4, 8'd9, 8'd7, 1'b1, 1'b0, 1'b1); tick(); drain();

        // Random operations on both instances concurrently
        for (int i = 0; i < 40; i++) begin
            issue(1, pick(), pick(), 1'($urandom), 1'($urandom), 1'b1);
            issue(4, pick(), pick(), 1'($urandom), 1'($urandom), 1'b1);
            tick();
            drain();
        end

        // start during CALC is ignored and operands are not re-sampled
        issue(1, 8'd10, 8'd20, 1'b0, 1'b0, 1'b1); tick();
        repeat (2) @(posedge clk);
        #1;
        issue(1, 8'd99, 8'd1, 1'b1, 1'b1, 1'b0); tick();
        a1 = 8'hAA; b1 = 8'h55; sel1 = 1'b1;
        drain();
        issue(4, 8'd33, 8'd44, 1'b1, 1'b1, 1'b1); tick();
        issue(4, 8'd7,  8'd7,  1'b0, 1'b0, 1'b0); tick();
        drain();

        // start during the DONE cycle: back-to-back without an idle cycle
        issue(1, 8'd120, 8'd9, 1'b0, 1'b1, 1'b1); tick();
        wait_done(1);
        issue(1, 8'd17, 8'd250, 1'b1, 1'b0, 1'b1); tick();
        drain();
        issue(4, 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b1); tick();
        wait_done(4);
        issue(4, 8'd255, 8'd255, 1'b0, 1'b0, 1'b1); tick();
        drain();

        // Asynchronous reset in the middle of an operation
        issue(1, 8'd50, 8'd60, 1'b0, 1'b0, 1'b1); tick();
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        q1.delete();
        q4.delete();
        #1;
        check_zero_outputs("midop_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        issue(1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1); tick(); drain();

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sumador_restador_serial.md
Name: sumador_restador_serial

Overview:
- Parametrised, multi-cycle add/subtract unit; the sequential successor to the combinational 4-bit adder/subtractor.
- Processes operands LSB-first, DIGIT bits per clock, using a start/busy/done handshake.
- Supports unsigned and two's-complement modes.
- Reports the raw wrapped result plus carry, true sign, exact magnitude and overflow, so downstream logic needs no correction stage.
- Sits between the operand register file and the result/display path.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
DIGIT, 1, bits processed per cycle; must divide WIDTH; N = WIDTH/DIGIT

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request operation; sampled only in IDLE or DONE
A  input  WIDTH  operand A, sampled at accepted start
B  input  WIDTH  operand B, sampled at accepted start
select  input  1  0 = A+B, 1 = A-B; sampled at accepted start
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accepted start
busy  output  1  operation in progress
done  output  1  one-cycle pulse; results valid from this cycle on
S  output  WIDTH  A+B or A-B modulo 2^WIDTH
Cout  output  1  final carry out of the MSB (subtraction carry = no borrow)
neg  output  1  true mathematical result < 0
mag  output  WIDTH+1  |true result|, exact
ovf  output  1  true result not representable in WIDTH bits in the selected mode

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE.
  - busy, done, S, Cout, neg, mag, ovf all 0.
  - Internal shift registers, carry and digit counter all 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE/DONE --start=1--> CALC.
  - DONE --start=0--> IDLE.
  - CALC --counter=N-1--> DONE.
  - Otherwise CALC holds.
- On accepted start (edge k), latch:
  - A
  - B XOR {WIDTH{select}}
  - carry = select
  - select and signed_mode
  - counter = 0
- CALC cycle: add the low DIGIT bits of both operand shift registers plus carry.
  - Shift the sum digit into the result register from the MSB side.
  - Update carry, increment counter.
  - On the last digit, also capture the carry into the MSB position; this is needed for signed overflow.
- Timing: digits are processed on edges k+1..k+N.
  - At edge k+N: S, Cout, neg, mag, ovf are loaded, state=DONE, done=1 for exactly one cycle.
  - busy=1 on cycles after edges k..k+N-1, 0 in DONE/IDLE.
  - Latency: done is high N cycles after the start edge.
- Result outputs hold their values until the next completion. They are not cleared by start.
- The true result R is the WIDTH+1-bit value:
  - unsigned: zero-extended A ± zero-extended B
  - signed: sign-extended A ± sign-extended B
- neg = R<0; mag = |R| (fits WIDTH+1 bits in all cases).
- ovf:
  - unsigned add: Cout
  - unsigned sub: ~Cout (negative result)
  - signed: carry-into-MSB XOR Cout
- start while in CALC: ignored; operands are not re-sampled.
- start during the DONE cycle: accepted; a back-to-back operation begins with no idle cycle.
- Reset mid-operation: abort immediately, no done pulse; the next start behaves normally.
- Input changes on A/B/select/signed_mode outside the accepted start edge have no effect.

Test Plan:
1. WIDTH=8, DIGIT=1, unsigned, select=1, A=3, B=5 -> S=0xFE, Cout=0, neg=1, mag=2, ovf=1; done exactly 8 cycles after start; busy high 8 cycles.
2. Unsigned add A=200, B=100 -> S=0x2C, Cout=1, ovf=1, neg=0, mag=300; unsigned add A=20, B=30 -> S=50, Cout=0, ovf=0, mag=50.
3. Signed add A=0x64, B=0x64 -> S=0xC8, ovf=1, neg=0, mag=200; signed sub A=0x80, B=0x01 -> S=0x7F, ovf=1, neg=1, mag=129; signed sub A=0x05, B=0x07 -> S=0xFE, ovf=0, neg=1, mag=2.
4. Instance WIDTH=8, DIGIT=4, unsigned sub A=9, B=7 -> S=2, Cout=1, neg=0, mag=2, ovf=0; done 2 cycles after start.
5. Start pulsed again mid-CALC with different operands -> ignored, first result unchanged; start during the DONE cycle -> second operation accepted, its done arrives N cycles later, no idle gap.
6. rst_n asserted asynchronously at digit 4 of 8 -> all outputs 0 immediately, no done pulse; subsequent unsigned add A=1, B=1 -> S=2, mag=2, done after 8 cycles.
